// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Holds DIGITS hex nibbles and time-multiplexes them onto one shared
// seven-segment bus with per-digit enables. Nibbles are loaded in parallel
// or shifted in serially from digit 0 upward. Provides an anti-ghost blank
// window at the start of each digit slot, per-digit decimal points,
// leading-zero suppression and selectable pin polarity.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   load       parallel capture of data_in / dp_in (wins over shift)
//   data_in    digit i in bits [4i+3:4i], digit 0 is rightmost
//   dp_in      decimal point per digit, captured with load
//   shift      shift digits up by one, nibble_in enters digit 0
//   nibble_in  nibble entered into digit 0 on shift
//   lzb        leading-zero blanking enable (live)
//   seg_out    segments, bit0 = a ... bit6 = g
//   dp_out     decimal point of the active digit
//   digit_en   one-hot enable of the active digit
module seg7_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int CLK_DIV      = 16,
  parameter int BLANK_CYCLES = 1,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  shift,
  input  logic [3:0]            nibble_in,
  input  logic                  lzb,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [4*DIGITS-1:0] nibbles;
  logic [DIGITS-1:0]   dps;
  logic [4*DIGITS-1:0] shifted_nibbles;
  logic [DIGITS-1:0]   shifted_dps;
  logic [PW-1:0]       pres;
  logic [IW-1:0]       idx;
  logic [DIGITS-1:0]   suppress;
  logic [DIGITS-1:0]   onehot;
  logic [3:0]          cur_nib;
  logic                cur_dp;
  logic                cur_sup;
  logic                in_window;
  logic                all_zero;
  logic                dp_above;
  logic [6:0]          seg_q;
  logic                dp_q;
  logic [DIGITS-1:0]   en_q;

  // Segment pattern (gfedcba, active-high) for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Serial entry moves every digit (and its dp) up one place; the shift
  // leaves zeros at the bottom which are then replaced by the new nibble.
  always_comb begin
    shifted_nibbles      = nibbles << 4;
    shifted_nibbles[3:0] = nibble_in;
    shifted_dps          = dps << 1;
  end

  // Digit storage; load takes priority over shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nibbles <= '0;
      dps     <= '0;
    end else if (load) begin
      nibbles <= data_in;
      dps     <= dp_in;
    end else if (shift) begin
      nibbles <= shifted_nibbles;
      dps     <= shifted_dps;
    end
  end

  // Slot prescaler and digit index; independent of storage activity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pres <= '0;
      idx  <= '0;
    end else if (pres == PRE_LAST) begin
      pres <= '0;
      idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      pres <= pres + 1'b1;
    end
  end

  // Walk from the top digit down: a digit is suppressed only while every
  // digit from it upward is zero and none of them carries a decimal point.
  always_comb begin
    all_zero = 1'b1;
    dp_above = 1'b0;
    suppress = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero    = all_zero & (nibbles[4*i +: 4] == 4'h0);
      dp_above    = dp_above | dps[i];
      suppress[i] = lzb && (i != 0) && all_zero && !dp_above;
    end
  end

  // Select the digit currently being scanned.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_sup = 1'b0;
    onehot  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = nibbles[4*i +: 4];
        cur_dp    = dps[i];
        cur_sup   = suppress[i];
        onehot[i] = 1'b1;
      end
    end
  end

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign in_window = 1'b1;
    end else begin : g_blank
      assign in_window = (pres >= PW'(BLANK_CYCLES));
    end
  endgenerate

  // Registered outputs, internally active-high; segments stay driven through
  // the blank window, only the enables are gated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      dp_q  <= 1'b0;
      en_q  <= '0;
    end else begin
      seg_q <= cur_sup ? 7'h00 : hex_to_seg(cur_nib);
      dp_q  <= cur_dp & ~cur_sup;
      en_q  <= (in_window && !cur_sup) ? onehot : '0;
    end
  end

  assign seg_out  = seg_q ^ {7{ACTIVE_LOW}};
  assign dp_out   = dp_q ^ ACTIVE_LOW;
  assign digit_en = en_q ^ {DIGITS{ACTIVE_LOW}};

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Self-checking bench for seg7_scan_driver. Two instances share stimulus:
// dut_a with default parameters and dut_b with ACTIVE_LOW=1, CLK_DIV=4,
// BLANK_CYCLES=2. A time-based reference model derives the expected pins
// for both every cycle; a vector table and short sequences pin down the
// decode values and corner cases by hand.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic        shift = 1'b0;
  logic        lzb = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  nibble_in = '0;

  logic [6:0]  seg_a, seg_b;
  logic        dp_a, dp_b;
  logic [3:0]  en_a, en_b;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state: cycles since reset release plus digit contents.
  int          t = 0;
  logic [3:0]  m_nib [4];
  logic        m_dp  [4];
  logic [6:0]  seg_tab [16];

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lz;
    int          digit;
    logic [6:0]  seg;
    logic        dpo;
    logic [3:0]  en;
  } vec_t;

  vec_t vecs [32];
  int   nvec = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(16), .BLANK_CYCLES(1), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
    .shift(shift), .nibble_in(nibble_in), .lzb(lzb),
    .seg_out(seg_a), .dp_out(dp_a), .digit_en(en_a)
  );

  seg7_scan_driver #(.DIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(2), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
    .shift(shift), .nibble_in(nibble_in), .lzb(lzb),
    .seg_out(seg_b), .dp_out(dp_b), .digit_en(en_b)
  );

  // Expected {seg, dp, en} for the scan state reached tt cycles after reset.
  function automatic logic [11:0] model_out(input int tt, input int cdiv, input int blank,
                                            input bit al, input logic lz);
    int         slot;
    int         pos;
    bit         sup;
    logic [6:0] s;
    logic       d;
    logic [3:0] e;
    slot = (tt / cdiv) % 4;
    pos  = tt % cdiv;
    sup  = 1'b0;
    if (lz && slot != 0) begin
      sup = 1'b1;
      for (int j = slot; j < 4; j++)
        if (m_nib[j] != 4'h0 || m_dp[j]) sup = 1'b0;
    end
    s = sup ? 7'h00 : seg_tab[m_nib[slot]];
    d = sup ? 1'b0 : m_dp[slot];
    e = (!sup && pos >= blank) ? (4'b0001 << slot) : 4'b0000;
    return {s, d, e} ^ {12{al}};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%h required=%h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_nib[i] = 4'h0;
      m_dp[i]  = 1'b0;
    end
    t = 0;
  endtask

  // One clock: predict both DUTs, update the model storage, then compare.
  task automatic tick();
    logic [11:0] ea;
    logic [11:0] eb;
    ea = model_out(t, 16, 1, 1'b0, lzb);
    eb = model_out(t, 4, 2, 1'b1, lzb);
    if (load) begin
      for (int i = 0; i < 4; i++) begin
        m_nib[i] = data_in[4*i +: 4];
        m_dp[i]  = dp_in[i];
      end
    end else if (shift) begin
      for (int i = 3; i > 0; i--) begin
        m_nib[i] = m_nib[i-1];
        m_dp[i]  = m_dp[i-1];
      end
      m_nib[0] = nibble_in;
      m_dp[0]  = 1'b0;
    end
    t++;
    @(posedge clk);
    #1;
    checkOutput("scan_a", 32'({seg_a, dp_a, en_a}), 32'(ea));
    checkOutput("scan_b", 32'({seg_b, dp_b, en_b}), 32'(eb));
  endtask

  task automatic applyStimulus(input logic ld, input logic sh, input logic [15:0] d,
                               input logic [3:0] dpv, input logic [3:0] nv);
    load      = ld;
    shift     = sh;
    data_in   = d;
    dp_in     = dpv;
    nibble_in = nv;
    tick();
    load  = 1'b0;
    shift = 1'b0;
  endtask

  // Advance until dut_a shows the last cycle of digit d's slot.
  task automatic wait_slot(input int d);
    int guard;
    guard = 0;
    while (!(((t / 16) % 4) == d && (t % 16) == 15) && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL wait_slot: digit %0d not reached within 100 cycles", d);
    end
    tick();
  endtask

  task automatic add_vec(input logic [15:0] d, input logic [3:0] dpv, input logic lz,
                         input int dig, input logic [6:0] s, input logic dpo, input logic [3:0] e);
    vecs[nvec].data  = d;
    vecs[nvec].dp    = dpv;
    vecs[nvec].lz    = lz;
    vecs[nvec].digit = dig;
    vecs[nvec].seg   = s;
    vecs[nvec].dpo   = dpo;
    vecs[nvec].en    = e;
    nvec++;
  endtask

  initial begin
    int cnt_a [4];
    int cnt_b [4];
    logic [15:0] rd;

    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    model_clear();

    // Reset held with a load request pending: nothing captured, pins inactive.
    #1 rst_n = 1'b0;
    load    = 1'b1;
    data_in = 16'h1234;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_a", 32'({seg_a, dp_a, en_a}), 32'h000);
    checkOutput("reset_b", 32'({seg_b, dp_b, en_b}), 32'hFFF);
    load = 1'b0;
    #2 rst_n = 1'b1;
    model_clear();
    tick();
    checkOutput("reset_no_capture", 32'({seg_a, dp_a, en_a}), 32'({7'h3F, 1'b0, 4'b0000}));

    // Decode table, scan order and leading-zero behaviour.
    add_vec(16'h1234, 4'b0000, 1'b0, 0, 7'h66, 1'b0, 4'b0001);
    add_vec(16'h1234, 4'b0000, 1'b0, 1, 7'h4F, 1'b0, 4'b0010);
    add_vec(16'h1234, 4'b0000, 1'b0, 2, 7'h5B, 1'b0, 4'b0100);
    add_vec(16'h1234, 4'b0000, 1'b0, 3, 7'h06, 1'b0, 4'b1000);
    add_vec(16'h0123, 4'b0000, 1'b0, 0, 7'h4F, 1'b0, 4'b0001);
    add_vec(16'h0123, 4'b0000, 1'b0, 1, 7'h5B, 1'b0, 4'b0010);
    add_vec(16'h0123, 4'b0000, 1'b0, 2, 7'h06, 1'b0, 4'b0100);
    add_vec(16'h0123, 4'b0000, 1'b0, 3, 7'h3F, 1'b0, 4'b1000);
    add_vec(16'h4567, 4'b0000, 1'b0, 0, 7'h07, 1'b0, 4'b0001);
    add_vec(16'h4567, 4'b0000, 1'b0, 1, 7'h7D, 1'b0, 4'b0010);
    add_vec(16'h4567, 4'b0000, 1'b0, 2, 7'h6D, 1'b0, 4'b0100);
    add_vec(16'h4567, 4'b0000, 1'b0, 3, 7'h66, 1'b0, 4'b1000);
    add_vec(16'h89AB, 4'b0000, 1'b0, 0, 7'h7C, 1'b0, 4'b0001);
    add_vec(16'h89AB, 4'b0000, 1'b0, 1, 7'h77, 1'b0, 4'b0010);
    add_vec(16'h89AB, 4'b0000, 1'b0, 2, 7'h6F, 1'b0, 4'b0100);
    add_vec(16'h89AB, 4'b0000, 1'b0, 3, 7'h7F, 1'b0, 4'b1000);
    add_vec(16'hCDEF, 4'b0000, 1'b0, 0, 7'h71, 1'b0, 4'b0001);
    add_vec(16'hCDEF, 4'b0000, 1'b0, 1, 7'h79, 1'b0, 4'b0010);
    add_vec(16'hCDEF, 4'b0000, 1'b0, 2, 7'h5E, 1'b0, 4'b0100);
    add_vec(16'hCDEF, 4'b0000, 1'b0, 3, 7'h39, 1'b0, 4'b1000);
    add_vec(16'h0070, 4'b0000, 1'b1, 3, 7'h00, 1'b0, 4'b0000);
    add_vec(16'h0070, 4'b0000, 1'b1, 2, 7'h00, 1'b0, 4'b0000);
    add_vec(16'h0070, 4'b0000, 1'b1, 1, 7'h07, 1'b0, 4'b0010);
    add_vec(16'h0070, 4'b0000, 1'b1, 0, 7'h3F, 1'b0, 4'b0001);
    add_vec(16'h0070, 4'b0100, 1'b1, 2, 7'h3F, 1'b1, 4'b0100);
    add_vec(16'h0070, 4'b0100, 1'b1, 3, 7'h00, 1'b0, 4'b0000);
    add_vec(16'h0070, 4'b0100, 1'b1, 1, 7'h07, 1'b0, 4'b0010);
    add_vec(16'h0000, 4'b0000, 1'b1, 0, 7'h3F, 1'b0, 4'b0001);

    for (int k = 0; k < nvec; k++) begin
      lzb = vecs[k].lz;
      applyStimulus(1'b1, 1'b0, vecs[k].data, vecs[k].dp, 4'h0);
      wait_slot(vecs[k].digit);
      checkOutput($sformatf("vec%0d", k), 32'({seg_a, dp_a, en_a}),
                  32'({vecs[k].seg, vecs[k].dpo, vecs[k].en}));
    end
    lzb = 1'b0;

    // Enable duty: one full 64-cycle scan of dut_a (4 scans of dut_b).
    applyStimulus(1'b1, 1'b0, 16'h1234, 4'b0000, 4'h0);
    while (t % 64 != 0) tick();
    for (int i = 0; i < 4; i++) begin
      cnt_a[i] = 0;
      cnt_b[i] = 0;
    end
    for (int c = 0; c < 64; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (en_a[i]) cnt_a[i]++;
        if (!en_b[i]) cnt_b[i]++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("duty_a%0d", i), 32'(cnt_a[i]), 32'd15);
      checkOutput($sformatf("duty_b%0d", i), 32'(cnt_b[i]), 32'd8);
    end

    // Serial entry, then load and shift together.
    applyStimulus(1'b1, 1'b0, 16'h0000, 4'b0000, 4'h0);
    applyStimulus(1'b0, 1'b1, 16'h0000, 4'b0000, 4'hA);
    applyStimulus(1'b0, 1'b1, 16'h0000, 4'b0000, 4'hB);
    applyStimulus(1'b0, 1'b1, 16'h0000, 4'b0000, 4'hC);
    wait_slot(0);
    checkOutput("serial_d0", 32'({seg_a, dp_a, en_a}), 32'({7'h39, 1'b0, 4'b0001}));
    wait_slot(1);
    checkOutput("serial_d1", 32'({seg_a, dp_a, en_a}), 32'({7'h7C, 1'b0, 4'b0010}));
    wait_slot(2);
    checkOutput("serial_d2", 32'({seg_a, dp_a, en_a}), 32'({7'h77, 1'b0, 4'b0100}));
    wait_slot(3);
    checkOutput("serial_d3", 32'({seg_a, dp_a, en_a}), 32'({7'h3F, 1'b0, 4'b1000}));
    applyStimulus(1'b1, 1'b1, 16'h5555, 4'b0000, 4'hF);
    wait_slot(0);
    checkOutput("load_wins_d0", 32'({seg_a, dp_a, en_a}), 32'({7'h6D, 1'b0, 4'b0001}));
    wait_slot(3);
    checkOutput("load_wins_d3", 32'({seg_a, dp_a, en_a}), 32'({7'h6D, 1'b0, 4'b1000}));

    // Inverted pins: an 8 lights every segment, so the bus is all low.
    applyStimulus(1'b1, 1'b0, 16'h8888, 4'b0000, 4'h0);
    tick();
    checkOutput("b_seg8", 32'(seg_b), 32'h00);

    // Randomised traffic against the model.
    lzb = 1'b1;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 4; i++)
        rd[4*i +: 4] = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
      if ($urandom_range(31) == 0) lzb = ~lzb;
      applyStimulus(($urandom_range(15) == 0), ($urandom_range(7) == 0), rd,
                    ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'h0,
                    4'($urandom_range(15)));
    end
    lzb = 1'b0;

    // Asynchronous reset in the middle of digit 2's slot.
    applyStimulus(1'b1, 1'b0, 16'h4321, 4'b0100, 4'h0);
    for (int g = 0; g < 100 && (t % 64) != 39; g++) tick();
    checkOutput("pre_reset_en", 32'(en_a), 32'b0100);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_a", 32'({seg_a, dp_a, en_a}), 32'h000);
    checkOutput("async_rst_b", 32'({seg_b, dp_b, en_b}), 32'hFFF);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("held_rst_a", 32'({seg_a, dp_a, en_a}), 32'h000);
    rst_n = 1'b1;
    model_clear();
    tick();
    checkOutput("restart_blank", 32'(en_a), 32'b0000);
    tick();
    checkOutput("restart_d0", 32'({seg_a, dp_a, en_a}), 32'({7'h3F, 1'b0, 4'b0001}));
    repeat (70) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
